sample_streamer: RTL and testbench

CPU-clock-domain audio sample pacer that sits directly upstream of the async FIFO feeding the PWM DAC. It buffers 12-bit samples written by the CPU over a valid/ready handshake, then releases exactly one sample per sample period on the async FIFO write port, honouring its full flag. On underflow it repeats the last sample so the DAC never starves, and it counts underflow events for software.

---
 rtl/sample_streamer_if.sv | 30 +++
 rtl/sample_streamer.sv | 128 ++++++++++++
 tb/tb_sample_streamer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_streamer_if.sv
// Sample handshake bundle: CPU-side valid/ready input and async-FIFO-side write port.
// The master modport is the environment (CPU and async FIFO); the slave modport is the streamer.
interface sample_streamer_if #(
    parameter int WIDTH = 12
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_full;

    modport master (
        output in_data,
        output in_valid,
        output out_full,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_full,
        output in_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/sample_streamer.sv
// Audio sample pacer: buffers CPU samples locally and releases one per sample period
// to the DAC async FIFO, repeating the last sample on underflow.
module sample_streamer #(
    parameter int WIDTH          = 12,
    parameter int DEPTH          = 8,
    parameter int CPU_CLOCK_FREQ = 95_000_000,
    parameter int SAMPLE_RATE    = 48_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     flush,
    sample_streamer_if.slave         bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              underflow_count
);
    localparam int DIV = CPU_CLOCK_FREQ / SAMPLE_RATE;
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [15:0]      ucnt_q, ucnt_d;

    logic             empty, full, tick, issue, push, pop;
    logic [WIDTH-1:0] head;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_FULL);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        tick  = enable && (cnt_q == CNT_LAST);
        issue = (pending_q || tick) && !bus.out_full && enable;
        // Flush wins over both ends of the FIFO on the same edge.
        push  = bus.in_valid && !full && !flush;
        pop   = issue && !empty && !flush;

        cnt_d = (!enable || tick) ? '0 : cnt_q + CW'(1);

        pending_d = pending_q;
        if (!enable || issue) begin
            pending_d = 1'b0;
        end else if (tick) begin
            pending_d = 1'b1;
        end

        out_valid_d = issue;
        out_data_d  = out_data_q;
        last_d      = last_q;
        ucnt_d      = ucnt_q;
        if (pop) begin
            out_data_d = head;
            last_d     = head;
        end else if (issue) begin
            out_data_d = last_q;
            if (ucnt_q != 16'hFFFF) begin
                ucnt_d = ucnt_q + 16'd1;
            end
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            last_q      <= '0;
            ucnt_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            last_q      <= last_d;
            ucnt_q      <= ucnt_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign level           = level_q;
    assign underflow_count = ucnt_q;
endmodule

// File: tb/tb_sample_streamer.sv
// Self-checking bench for sample_streamer with DIV=8, using a queue-based reference model.
module tb_sample_streamer;
    localparam int WIDTH = 12;
    localparam int DEPTH = 8;
    localparam int DIV   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  level;
    logic [15:0] underflow_count;

    sample_streamer_if #(.WIDTH(WIDTH)) bus ();

    sample_streamer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CPU_CLOCK_FREQ(8), .SAMPLE_RATE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .bus(bus.slave), .level(level), .underflow_count(underflow_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_last;
    logic [WIDTH-1:0] m_od;
    int               m_phase;
    int               m_ucnt;
    bit               m_pend;
    bit               m_ov;

    logic [WIDTH-1:0] s_full[8];

    task automatic model_reset();
        mq.delete();
        m_last  = '0;
        m_od    = '0;
        m_phase = 0;
        m_ucnt  = 0;
        m_pend  = 1'b0;
        m_ov    = 1'b0;
    endtask

    // Advance the reference model by one period of clk, then step past the edge.
    task automatic cyc();
        bit tick, issue, rdy;
        logic [WIDTH-1:0] v;
        tick  = enable && (((m_phase + 1) % DIV) == 0);
        issue = (m_pend || tick) && !bus.out_full && enable;
        rdy   = (mq.size() < DEPTH);
        m_ov  = issue;
        if (issue) begin
            if (!flush && mq.size() > 0) begin
                v = mq.pop_front();
                m_last = v;
            end else begin
                v = m_last;
                if (m_ucnt < 65535) m_ucnt++;
            end
            m_od = v;
        end
        if (!enable || issue) m_pend = 1'b0;
        else if (tick) m_pend = 1'b1;
        if (flush) mq.delete();
        else if (bus.in_valid && rdy) mq.push_back(bus.in_data);
        m_phase = enable ? (m_phase + 1) % DIV : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_full = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        tests++; if (bus.out_data !== 12'h000) begin fails++; $display("FAIL reset_out_data got=%h exp=000", bus.out_data); end
        tests++; if (level !== 4'd0) begin fails++; $display("FAIL reset_level got=%0d exp=0", level); end
        tests++; if (underflow_count !== 16'd0) begin fails++; $display("FAIL reset_ucnt got=%0d exp=0", underflow_count); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int pulses[$];
        logic [WIDTH-1:0] pd[$];
        logic [WIDTH-1:0] exp_d[3];
        exp_d[0] = 12'h111; exp_d[1] = 12'h222; exp_d[2] = 12'h333;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_data = exp_d[i];
            cyc();
        end
        bus.in_valid = 1'b0;
        tests++; if (level !== 4'd3) begin fails++; $display("FAIL basic_level_pre got=%0d exp=3", level); end
        enable = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            cyc();
            tests++; if (bus.out_valid !== m_ov) begin fails++; $display("FAIL basic_valid c=%0d got=%0b exp=%0b", c, bus.out_valid, m_ov); end
            if (bus.out_valid) begin pulses.push_back(c); pd.push_back(bus.out_data); end
        end
        tests++;
        if (pulses.size() != 3) begin
            fails++; $display("FAIL basic_pulse_count got=%0d exp=3", pulses.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++; if (pulses[i] != 8 * (i + 1)) begin fails++; $display("FAIL basic_pulse_time i=%0d got=%0d exp=%0d", i, pulses[i], 8 * (i + 1)); end
                tests++; if (pd[i] !== exp_d[i]) begin fails++; $display("FAIL basic_pulse_data i=%0d got=%h exp=%h", i, pd[i], exp_d[i]); end
            end
        end
        tests++; if (level !== 4'd0) begin fails++; $display("FAIL basic_level_post got=%0d exp=0", level); end
    endtask

    task automatic test_underflow();
        int n = 0;
        for (int c = 1; c <= 16; c++) begin
            cyc();
            tests++; if (bus.out_valid !== m_ov) begin fails++; $display("FAIL uf_valid c=%0d got=%0b exp=%0b", c, bus.out_valid, m_ov); end
            if (bus.out_valid) begin
                n++;
                tests++; if (bus.out_data !== 12'h333) begin fails++; $display("FAIL uf_data got=%h exp=333", bus.out_data); end
            end
        end
        tests++; if (n != 2) begin fails++; $display("FAIL uf_pulse_count got=%0d exp=2", n); end
        tests++; if (underflow_count !== 16'd2) begin fails++; $display("FAIL uf_count got=%0d exp=2", underflow_count); end
    endtask

    task automatic test_full_fifo();
        int hit = 0;
        enable = 1'b0;
        cyc();
        for (int i = 0; i < 8; i++) begin
            s_full[i] = WIDTH'($urandom);
            bus.in_valid = 1'b1; bus.in_data = s_full[i];
            cyc();
        end
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready got=%0b exp=0", bus.in_ready); end
        bus.in_data = WIDTH'($urandom);
        cyc();
        bus.in_valid = 1'b0;
        tests++; if (level !== 4'd8) begin fails++; $display("FAIL full_level got=%0d exp=8", level); end
        enable = 1'b1;
        for (int c = 1; c <= 3 * DIV && hit == 0; c++) begin
            cyc();
            if (bus.out_valid) hit = c;
        end
        tests++;
        if (hit == 0) begin
            fails++; $display("FAIL full_timeout got=no_pulse exp=pulse");
        end else begin
            tests++; if (hit != DIV) begin fails++; $display("FAIL full_first_time got=%0d exp=%0d", hit, DIV); end
            tests++; if (bus.out_data !== s_full[0]) begin fails++; $display("FAIL full_first_data got=%h exp=%h", bus.out_data, s_full[0]); end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        bus.out_full = 1'b1;
        for (int c = 0; c < 3 * DIV; c++) begin
            cyc();
            if (bus.out_valid) n++;
        end
        tests++; if (n != 0) begin fails++; $display("FAIL bp_held_pulses got=%0d exp=0", n); end
        bus.out_full = 1'b0;
        cyc();
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_release_valid got=%0b exp=1", bus.out_valid); end
        tests++; if (bus.out_data !== s_full[1]) begin fails++; $display("FAIL bp_release_data got=%h exp=%h", bus.out_data, s_full[1]); end
        tests++; if (level !== 4'd6) begin fails++; $display("FAIL bp_level got=%0d exp=6", level); end
        cyc();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_single_pulse got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_async_reset();
        int hit = 0;
        for (int c = 0; c < 2 * DIV && hit == 0; c++) begin
            cyc();
            if (bus.out_valid) hit = 1;
        end
        tests++; if (hit == 0) begin fails++; $display("FAIL areset_timeout got=no_pulse exp=pulse"); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL areset_out_valid got=%0b exp=0", bus.out_valid); end
        tests++; if (level !== 4'd0) begin fails++; $display("FAIL areset_level got=%0d exp=0", level); end
        tests++; if (underflow_count !== 16'd0) begin fails++; $display("FAIL areset_ucnt got=%0d exp=0", underflow_count); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL areset_in_ready got=%0b exp=1", bus.in_ready); end
        enable = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_flush();
        logic [WIDTH-1:0] f[6];
        int hit = 0;
        for (int i = 0; i < 6; i++) begin
            f[i] = WIDTH'($urandom);
            bus.in_valid = 1'b1; bus.in_data = f[i];
            cyc();
        end
        bus.in_valid = 1'b0;
        enable = 1'b1;
        for (int c = 0; c < 2 * DIV && hit == 0; c++) begin
            cyc();
            if (bus.out_valid) hit = 1;
        end
        tests++; if (hit == 0 || bus.out_data !== f[0]) begin fails++; $display("FAIL flush_first got=%h exp=%h", bus.out_data, f[0]); end
        tests++; if (level !== 4'd5) begin fails++; $display("FAIL flush_level_pre got=%0d exp=5", level); end
        flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = WIDTH'($urandom);
        cyc();
        flush = 1'b0; bus.in_valid = 1'b0;
        tests++; if (level !== 4'd0) begin fails++; $display("FAIL flush_level got=%0d exp=0", level); end
        hit = 0;
        for (int c = 0; c < 2 * DIV && hit == 0; c++) begin
            cyc();
            if (bus.out_valid) hit = 1;
        end
        tests++; if (hit == 0 || bus.out_data !== f[0]) begin fails++; $display("FAIL flush_repeat got=%h exp=%h", bus.out_data, f[0]); end
        tests++; if (underflow_count !== 16'd1) begin fails++; $display("FAIL flush_ucnt got=%0d exp=1", underflow_count); end
    endtask

    task automatic test_random();
        int pv;
        rst_n = 1'b0;
        enable = 1'b0; flush = 1'b0; bus.in_valid = 1'b0; bus.out_full = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;
        for (int c = 0; c < 800; c++) begin
            pv = (c < 400) ? 40 : 5;
            if ($urandom_range(0, 99) < 2) enable = ~enable;
            bus.in_valid = ($urandom_range(0, 99) < pv);
            bus.in_data  = WIDTH'($urandom);
            bus.out_full = ($urandom_range(0, 99) < 25);
            flush        = ($urandom_range(0, 99) < 1);
            cyc();
            tests++; if (bus.out_valid !== m_ov) begin fails++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, bus.out_valid, m_ov); end
            if (m_ov) begin
                tests++; if (bus.out_data !== m_od) begin fails++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, bus.out_data, m_od); end
            end
            tests++; if (level !== 4'(mq.size())) begin fails++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, level, mq.size()); end
            tests++; if (bus.in_ready !== (mq.size() < DEPTH)) begin fails++; $display("FAIL rnd_in_ready c=%0d got=%0b exp=%0b", c, bus.in_ready, mq.size() < DEPTH); end
            tests++; if (underflow_count !== 16'(m_ucnt)) begin fails++; $display("FAIL rnd_ucnt c=%0d got=%0d exp=%0d", c, underflow_count, m_ucnt); end
        end
        flush = 1'b0; bus.in_valid = 1'b0; bus.out_full = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_full_fifo();
        test_backpressure();
        test_async_reset();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
